// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALUOp encodings and control-bundle bit positions for the
// pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam int MEM_W = 4;
    localparam int WB_W  = 2;

    // EX bundle is {RegDst, ALUOp, ALUSrc}; RegDst sits above the ALUOp field.
    localparam int EX_ALUSRC    = 0;
    localparam int EX_ALUOP_LSB = 1;

    localparam int M_BRANCH   = 3;
    localparam int M_BRANCHNE = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    function automatic int ex_regdst_idx(input int aluop_w);
        return aluop_w + 1;
    endfunction

    function automatic logic uses_rt(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Combinational opcode decoder: produces EX/MEM/WB control bundles and an
// illegal flag for any opcode outside the supported set.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]      op,
    output logic [ALUOP_W+1:0]   ex,
    output logic [MEM_W-1:0]     m,
    output logic [WB_W-1:0]      wb,
    output logic                 illegal
);

    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;

    always_comb begin
        reg_dst = 1'b0;
        alu_src = 1'b0;
        alu_op  = '0;
        m       = '0;
        wb      = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_dst         = 1'b1;
                alu_op          = ALUOP_W'(ALU_RTYPE);
                wb[WB_REGWRITE] = 1'b1;
            end
            OP_LW: begin
                alu_op          = ALUOP_W'(ALU_ADD);
                alu_src         = 1'b1;
                m[M_MEMREAD]    = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
                wb[WB_MEMTOREG] = 1'b1;
            end
            OP_SW: begin
                alu_op        = ALUOP_W'(ALU_ADD);
                alu_src       = 1'b1;
                m[M_MEMWRITE] = 1'b1;
            end
            OP_BEQ: begin
                alu_op      = ALUOP_W'(ALU_SUB);
                m[M_BRANCH] = 1'b1;
            end
            OP_BNE: begin
                alu_op        = ALUOP_W'(ALU_SUB);
                m[M_BRANCH]   = 1'b1;
                m[M_BRANCHNE] = 1'b1;
            end
            OP_ADDI: begin
                alu_op          = ALUOP_W'(ALU_ADD);
                alu_src         = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
            end
            OP_ANDI: begin
                alu_op          = ALUOP_W'(ALU_AND);
                alu_src         = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
            end
            OP_ORI: begin
                alu_op          = ALUOP_W'(ALU_OR);
                alu_src         = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
            end
            OP_SLTI: begin
                alu_op          = ALUOP_W'(ALU_SLT);
                alu_src         = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
            end
            OP_LUI: begin
                alu_op          = ALUOP_W'(ALU_LUI);
                alu_src         = 1'b1;
                wb[WB_REGWRITE] = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ex = {reg_dst, alu_op, alu_src};

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through ID/EX, EX/MEM,
// MEM/WB, and handles load-use stalls, branch flushes and a stall counter.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int OP_W      = 6,
    parameter int ALUOP_W   = 3,
    parameter int CNT_W     = 16,
    parameter int HAZARD_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_op,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               flush,
    output logic [ALUOP_W+1:0] ex_ctrl,
    output logic [MEM_W-1:0]   mem_ctrl,
    output logic [WB_W-1:0]    wb_ctrl,
    output logic [REG_W-1:0]   wb_dst,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int EX_W      = ALUOP_W + 2;
    localparam int EX_REGDST = ex_regdst_idx(ALUOP_W);

    logic [EX_W-1:0]  dec_ex;
    logic [MEM_W-1:0] dec_m;
    logic [WB_W-1:0]  dec_wb;
    logic             dec_ill;
    logic [REG_W-1:0] dec_dst;

    logic [EX_W-1:0]  idex_ex;
    logic [MEM_W-1:0] idex_m,   exmem_m;
    logic [WB_W-1:0]  idex_wb,  exmem_wb,  memwb_wb;
    logic [REG_W-1:0] idex_dst, exmem_dst, memwb_dst;
    logic             idex_ill;

    logic stall;
    logic bubble;

    ctrl_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .op      (id_op),
        .ex      (dec_ex),
        .m       (dec_m),
        .wb      (dec_wb),
        .illegal (dec_ill)
    );

    assign dec_dst = dec_ex[EX_REGDST] ? id_rd : id_rt;

    // A load in EX whose result the ID instruction reads must hold IF/ID one cycle.
    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign stall = id_valid && idex_m[M_MEMREAD] && (idex_dst != '0) &&
                           ((idex_dst == id_rs) ||
                            ((idex_dst == id_rt) && uses_rt(id_op)));
        end else begin : g_no_hazard
            assign stall = 1'b0;
        end
    endgenerate

    // Flush wins over stall: the instructions being held are squashed anyway.
    assign pc_write   = !stall || flush;
    assign ifid_write = !stall || flush;
    assign ifid_flush = flush;
    assign bubble     = flush || stall || !id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex  <= '0;
            idex_m   <= '0;
            idex_wb  <= '0;
            idex_dst <= '0;
            idex_ill <= 1'b0;
        end else if (bubble) begin
            idex_ex  <= '0;
            idex_m   <= '0;
            idex_wb  <= '0;
            idex_dst <= '0;
            idex_ill <= 1'b0;
        end else begin
            idex_ex  <= dec_ex;
            idex_m   <= dec_m;
            idex_wb  <= dec_wb;
            idex_dst <= dec_dst;
            idex_ill <= dec_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_m   <= '0;
            exmem_wb  <= '0;
            exmem_dst <= '0;
        end else if (flush) begin
            exmem_m   <= '0;
            exmem_wb  <= '0;
            exmem_dst <= '0;
        end else begin
            exmem_m   <= idex_m;
            exmem_wb  <= idex_wb;
            exmem_dst <= idex_dst;
        end
    end

    // MEM/WB is never flushed so the resolving branch itself retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_wb  <= '0;
            memwb_dst <= '0;
        end else begin
            memwb_wb  <= exmem_wb;
            memwb_dst <= exmem_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ex_ctrl    = idex_ex;
    assign mem_ctrl   = exmem_m;
    assign wb_ctrl    = memwb_wb;
    assign wb_dst     = memwb_dst;
    assign illegal_op = idex_ill;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Next-generation pipelined control unit for the 5-stage MIPS core. Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers, together with the destination register number. Adds load-use hazard detection (stall plus bubble), branch flush and illegal-opcode flagging. Also provides a saturating stall counter. Sits between the IF/ID register and the datapath pipeline registers.

Parameters:
REG_W, 5, register-address width (rs/rt/rd/dst)
OP_W, 6, opcode width
ALUOP_W, 3, ALUOp width; must be >=3
CNT_W, 16, stall-counter width
HAZARD_EN, 1, 1 = load-use detection active; 0 = stall tied low

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_op  in  OP_W  opcode of the ID-stage instruction
id_rs  in  REG_W  rs field
id_rt  in  REG_W  rt field
id_rd  in  REG_W  rd field
flush  in  1  branch taken, resolved in MEM
ex_ctrl  out  ALUOP_W+2  {RegDst, ALUOp, ALUSrc} from ID/EX
mem_ctrl  out  4  {Branch, BranchNe, MemRead, MemWrite} from EX/MEM
wb_ctrl  out  2  {RegWrite, MemtoReg} from MEM/WB
wb_dst  out  REG_W  destination register from MEM/WB
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  clear IF/ID
illegal_op  out  1  registered; undefined opcode entered ID/EX
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Decode:
  - R-type 000000: RegDst=1, ALUOp=010, ALUSrc=0, RegWrite=1.
  - lw 100011: ALUOp=000, ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1.
  - sw 101011: ALUOp=000, ALUSrc=1, MemWrite=1.
  - beq 000100: ALUOp=001, Branch=1.
  - bne 000101: ALUOp=001, Branch=1, BranchNe=1.
  - addi 001000: ALUOp=000, ALUSrc=1, RegWrite=1.
  - andi 001100: ALUOp=011, ALUSrc=1, RegWrite=1.
  - ori 001101: ALUOp=100, ALUSrc=1, RegWrite=1.
  - slti 001010: ALUOp=101, ALUSrc=1, RegWrite=1.
  - lui 001111: ALUOp=110, ALUSrc=1, RegWrite=1.
  - Unlisted bits are 0; no X values are driven.
  - Any other opcode decodes to all-zero control with illegal=1.
- dst = RegDst ? id_rd : id_rt. It is captured into ID/EX and follows the control bundle through EX/MEM and MEM/WB.
- Latency: ex_ctrl is valid 1 cycle after id_op is presented, mem_ctrl after 2, wb_ctrl and wb_dst after 3. There is no internal combinational path from id_op to any output except stall-related outputs.
- rt-as-source opcodes: R-type, sw, beq, bne.
- Load-use stall (combinational) asserts when all of the following hold:
  - HAZARD_EN=1 and id_valid=1;
  - ID/EX MemRead=1 and ID/EX dst != 0;
  - ID/EX dst == id_rs, or (ID/EX dst == id_rt and the opcode uses rt as a source).
- On stall:
  - pc_write=0, ifid_write=0;
  - the next ID/EX load is all-zero control (bubble), with illegal=0;
  - EX/MEM and MEM/WB advance normally.
- id_valid=0 loads a bubble into ID/EX.
- flush=1:
  - ifid_flush=1 in the same cycle;
  - next edge zeroes the ID/EX and EX/MEM control;
  - MEM/WB still captures the old EX/MEM contents, so the branch itself retires.
- flush overrides stall: when both are 1, pc_write=1, ifid_write=1, and the stall counter does not increment.
- stall_cnt increments by 1 on each edge where stall=1 and flush=0. It saturates at all-ones and never wraps.
- illegal_op is registered alongside ID/EX and is cleared by a bubble or a flush.
- Reset (asynchronous, any time, including mid-stall):
  - all pipeline registers, wb_dst, illegal_op and stall_cnt clear to 0;
  - consequently stall=0, so pc_write=1, ifid_write=1, ifid_flush=flush.
  - The first edge after release loads the current id_op normally.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams;
  - ALUOp encodings;
  - bundle widths and bit-index constants (RegDst, ALUSrc, Branch, BranchNe, MemRead, MemWrite, RegWrite, MemtoReg);
  - a function uses_rt(op).
- Sub-module ctrl_decode: purely combinational op -> {ex, m, wb, illegal}.
- The top level holds the pipeline registers, hazard logic and counter.

Test Plan:
- Reset then R-type (rd=3): ex_ctrl={1,010,0} at +1, mem_ctrl=0000 at +2, wb_ctrl=10 and wb_dst=3 at +3.
- lw rt=5, then add rs=5: stall=1 for exactly 1 cycle, pc_write=0, ifid_write=0; bubble in ID/EX; add issues the next cycle; stall_cnt=1.
- lw rt=0, then add rs=0: no stall. lw rt=7, then addi rt=7 (rt not a source): no stall.
- beq in EX/MEM with flush=1 on the same edge as a load-use stall: ifid_flush=1, pc_write=1; ID/EX and EX/MEM control = 0 on the next cycle; stall_cnt unchanged.
- Opcode 111111: illegal_op=1 at +1 with all-zero ex_ctrl; a following addi clears illegal_op.
- CNT_W=2 with 5 consecutive stalls: stall_cnt=3 and holds. Asserting rst_n=0 mid-stall clears all outputs asynchronously.
